// File: rtl/mfp_ahb_intc.sv
// AHB-Lite interrupt controller: synchronised request lines, per-channel enable/mode,
// W1C pending register, vector register and ack pulses. Optional overflow register: MFP_INTC_OVF_EN.
module mfp_ahb_intc #(
   parameter int N_CH        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            HCLK,
   input  logic            SI_Reset,
   input  logic            HSEL,
   input  logic [31:0]     HADDR,
   input  logic [1:0]      HTRANS,
   input  logic            HWRITE,
   input  logic [31:0]     HWDATA,
   output logic [31:0]     HRDATA,
   input  logic [N_CH-1:0] IO_IntReq,
   output logic [N_CH-1:0] IO_IntAck,
   output logic            IRQ
);

   localparam logic [2:0] OFF_PEND = 3'd0;
   localparam logic [2:0] OFF_EN   = 3'd1;
   localparam logic [2:0] OFF_VEC  = 3'd2;
   localparam logic [2:0] OFF_MODE = 3'd3;
   localparam logic [2:0] OFF_OVF  = 3'd4;

   // Bus handshake: no wait states and no error response, so a selected active
   // transfer always completes with its data phase in the following cycle.
   logic                                 bus_act;
   logic                                 dph_wr;
   logic [2:0]                           dph_off;
   logic [SYNC_STAGES-1:0][N_CH-1:0]     sync_q;
   logic [N_CH-1:0]                      req_s, hist_q, edge_det;
   logic [N_CH-1:0]                      pend, en, mode;
   logic [N_CH-1:0]                      wdat, pend_clr, set_v, pend_nxt, ack_nxt, masked;
   logic [4:0]                           vec_idx;
   logic [31:0]                          rd_val;
   logic                                 unused_bits;

   assign bus_act     = HSEL & HTRANS[1];
   assign wdat        = HWDATA[N_CH-1:0];
   assign req_s       = sync_q[SYNC_STAGES-1];
   assign edge_det    = req_s & ~hist_q;
   assign masked      = pend & en;
   assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

   always_ff @(posedge HCLK or posedge SI_Reset) begin
      if (SI_Reset) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         sync_q[0] <= IO_IntReq;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         hist_q <= req_s;
      end
   end

   always_ff @(posedge HCLK or posedge SI_Reset) begin
      if (SI_Reset) begin
         dph_wr  <= 1'b0;
         dph_off <= 3'd0;
      end else begin
         dph_wr <= bus_act & HWRITE;
         if (bus_act) dph_off <= HADDR[4:2];
      end
   end

   // A set in the same cycle as a clear wins, and suppresses that bit's ack.
   always_comb begin
      pend_clr = (dph_wr && dph_off == OFF_PEND) ? wdat : '0;
      set_v    = (mode & edge_det) | (~mode & req_s);
      pend_nxt = (pend & ~pend_clr) | set_v;
      ack_nxt  = pend & pend_clr & ~set_v;
   end

   always_ff @(posedge HCLK or posedge SI_Reset) begin
      if (SI_Reset) begin
         pend      <= '0;
         en        <= '0;
         mode      <= '0;
         IO_IntAck <= '0;
         IRQ       <= 1'b0;
      end else begin
         pend      <= pend_nxt;
         IO_IntAck <= ack_nxt;
         IRQ       <= |masked;
         if (dph_wr && dph_off == OFF_EN)   en   <= wdat;
         if (dph_wr && dph_off == OFF_MODE) mode <= wdat;
      end
   end

`ifdef MFP_INTC_OVF_EN
   logic [N_CH-1:0] ovf, ovf_clr, ovf_set;

   // Overflow: a fresh edge lands on a pending bit that is not being cleared now.
   always_comb begin
      ovf_clr = (dph_wr && dph_off == OFF_OVF) ? wdat : '0;
      ovf_set = mode & edge_det & pend & ~pend_clr;
   end

   always_ff @(posedge HCLK or posedge SI_Reset) begin
      if (SI_Reset) ovf <= '0;
      else          ovf <= (ovf & ~ovf_clr) | ovf_set;
   end
`endif

   always_comb begin
      vec_idx = 5'd0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (masked[i]) vec_idx = 5'(i);
      end
   end

   always_comb begin
      rd_val = '0;
      case (HADDR[4:2])
         OFF_PEND: rd_val[N_CH-1:0] = pend;
         OFF_EN:   rd_val[N_CH-1:0] = en;
         OFF_VEC:  if (|masked) rd_val = {1'b1, 26'd0, vec_idx};
         OFF_MODE: rd_val[N_CH-1:0] = mode;
`ifdef MFP_INTC_OVF_EN
         OFF_OVF:  rd_val[N_CH-1:0] = ovf;
`endif
         default:  rd_val = '0;
      endcase
   end

   always_ff @(posedge HCLK or posedge SI_Reset) begin
      if (SI_Reset) HRDATA <= '0;
      else          HRDATA <= (bus_act & ~HWRITE) ? rd_val : 32'd0;
   end

endmodule

// File: tb/tb_mfp_ahb_intc.sv
// Directed bench for mfp_ahb_intc: bus tasks, ack pulse counter, assertion checks.
module tb_mfp_ahb_intc;
   logic        HCLK = 1'b0;
   logic        SI_Reset = 1'b1;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = '0;
   logic        HWRITE = 1'b0;
   logic [31:0] HWDATA = '0;
   logic [31:0] HRDATA;
   logic [7:0]  IO_IntReq = '0;
   logic [7:0]  IO_IntAck;
   logic        IRQ;

   int errors = 0;
   int checks = 0;
   int ack_cnt [8];
   logic [31:0] rd;

   mfp_ahb_intc #(.N_CH(8), .SYNC_STAGES(2)) dut (
      .HCLK(HCLK), .SI_Reset(SI_Reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .IO_IntReq(IO_IntReq),
      .IO_IntAck(IO_IntAck), .IRQ(IRQ)
   );

   always #5 HCLK = ~HCLK;

   initial for (int i = 0; i < 8; i++) ack_cnt[i] = 0;

   always @(negedge HCLK) begin
      if (!SI_Reset)
         for (int i = 0; i < 8; i++) if (IO_IntAck[i]) ack_cnt[i] = ack_cnt[i] + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
      tick(1);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
      tick(1);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
      tick(1);
      data = HRDATA;
      HSEL = 1'b0; HTRANS = 2'b00;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      tick(3);
      SI_Reset = 1'b0;
      tick(1);
      bus_read(32'h00, rd); check("rst_pend", rd, 32'h0);
      bus_read(32'h04, rd); check("rst_en", rd, 32'h0);
      bus_read(32'h08, rd); check("rst_vec", rd, 32'h0);
      bus_read(32'h0C, rd); check("rst_mode", rd, 32'h0);
      check("rst_irq", {31'd0, IRQ}, 32'h0);
      check("rst_ack", {24'd0, IO_IntAck}, 32'h0);

      // Single edge on ch5: latency, vector, W1C and ack
      bus_write(32'h04, 32'hFF);
      bus_write(32'h0C, 32'hFF);
      bus_read(32'h0C, rd); check("mode_rb", rd, 32'hFF);
      IO_IntReq[5] = 1'b1;
      tick(1);
      IO_IntReq[5] = 1'b0;
      tick(2);
      check("irq_e3", {31'd0, IRQ}, 32'h0);
      tick(1);
      check("irq_e4", {31'd0, IRQ}, 32'h1);
      bus_read(32'h00, rd); check("pend_ch5", rd, 32'h20);
      bus_read(32'h08, rd); check("vec_ch5", rd, 32'h80000005);
      bus_write(32'h00, 32'h20);
      check("ack5_pulse", {24'd0, IO_IntAck}, 32'h20);
      check("irq_hold", {31'd0, IRQ}, 32'h1);
      tick(1);
      check("ack5_end", {24'd0, IO_IntAck}, 32'h0);
      check("irq_drop", {31'd0, IRQ}, 32'h0);
      check("ack5_cnt", ack_cnt[5], 32'd1);
      bus_read(32'h00, rd); check("pend_clr5", rd, 32'h0);

      // Priority: ch2 and ch6 pending, enable masks the vector
      IO_IntReq = 8'h44;
      tick(1);
      IO_IntReq = 8'h00;
      tick(4);
      bus_write(32'h04, 32'h40);
      bus_read(32'h08, rd); check("vec_ch6", rd, 32'h80000006);
      bus_write(32'h04, 32'h44);
      bus_read(32'h08, rd); check("vec_ch2", rd, 32'h80000002);
      bus_write(32'h04, 32'h00);
      bus_read(32'h08, rd); check("vec_none", rd, 32'h0);
      bus_read(32'h00, rd); check("pend_dis", rd, 32'h44);
      bus_write(32'h00, 32'h44);
      tick(2);
      check("ack2_cnt", ack_cnt[2], 32'd1);
      check("ack6_cnt", ack_cnt[6], 32'd1);

      // Level mode on ch3: W1C has no lasting effect while the line is high
      bus_write(32'h0C, 32'hF7);
      IO_IntReq[3] = 1'b1;
      tick(4);
      bus_write(32'h00, 32'h08);
      tick(1);
      bus_read(32'h00, rd); check("lvl_hold", rd, 32'h08);
      check("lvl_noack", ack_cnt[3], 32'd0);
      IO_IntReq[3] = 1'b0;
      tick(4);
      bus_write(32'h00, 32'h08);
      tick(2);
      bus_read(32'h00, rd); check("lvl_clr", rd, 32'h0);
      check("lvl_ack", ack_cnt[3], 32'd1);

      // Edge on ch1 coincides with the W1C data phase for ch1
      IO_IntReq[1] = 1'b1;
      tick(1);
      IO_IntReq[1] = 1'b0;
      tick(4);
      IO_IntReq[1] = 1'b1;
      tick(1);
      IO_IntReq[1] = 1'b0;
      bus_write(32'h00, 32'h02);
      tick(2);
      bus_read(32'h00, rd); check("race_pend", rd, 32'h02);
      check("race_noack", ack_cnt[1], 32'd0);
      bus_write(32'h00, 32'h02);
      tick(1);
      check("race_ack", ack_cnt[1], 32'd1);
      bus_read(32'h00, rd); check("race_clr", rd, 32'h0);

      // Overflow register / unmapped offsets
      IO_IntReq[0] = 1'b1;
      tick(1);
      IO_IntReq[0] = 1'b0;
      tick(3);
      IO_IntReq[0] = 1'b1;
      tick(1);
      IO_IntReq[0] = 1'b0;
      tick(4);
      bus_read(32'h00, rd); check("ovf_pend", rd, 32'h01);
`ifdef MFP_INTC_OVF_EN
      bus_read(32'h10, rd); check("ovf_set", rd, 32'h01);
      bus_write(32'h10, 32'h01);
      bus_read(32'h10, rd); check("ovf_clr", rd, 32'h0);
`else
      bus_write(32'h10, 32'hFFFFFFFF);
      bus_read(32'h10, rd); check("ovf_absent", rd, 32'h0);
`endif
      bus_write(32'h14, 32'hFFFFFFFF);
      bus_read(32'h14, rd); check("unmapped", rd, 32'h0);
      bus_write(32'h00, 32'h01);
      tick(1);

      // Reset mid-operation with a request still held high
      bus_write(32'h04, 32'hFF);
      IO_IntReq[7] = 1'b1;
      tick(4);
      check("pre_rst_irq", {31'd0, IRQ}, 32'h1);
      SI_Reset = 1'b1;
      #1;
      check("async_rst_irq", {31'd0, IRQ}, 32'h0);
      tick(1);
      SI_Reset = 1'b0;
      tick(5);
      bus_read(32'h04, rd); check("rst2_en", rd, 32'h0);
      bus_read(32'h00, rd); check("rst2_pend", rd, 32'h80);
      check("rst2_irq", {31'd0, IRQ}, 32'h0);
      IO_IntReq = 8'h00;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mfp_ahb_intc.md
Name: mfp_ahb_intc

Overview:
- Parametrised AHB-Lite slave interrupt controller for N_CH external request lines. Examples: bot update, switches, UART.
- Generalises the single bot-update request/ack pair into a multi-channel block with per-channel enable, edge/level mode, priority vector and per-channel ack pulses.
- Sits on the AHB-Lite bus beside the GPIO slaves.
- Drives one interrupt line into the core's SI_Int input.

Parameters:
- N_CH, 8, number of request channels; legal range 1..32.
- SYNC_STAGES, 2, synchroniser flops per request input; legal range 2..3.

Ports:
- HCLK  input  1  bus clock; all logic on rising edge.
- SI_Reset  input  1  asynchronous, active-high reset.
- HSEL  input  1  slave select from AHB decoder.
- HADDR  input  32  bus address; only HADDR[4:2] decoded.
- HTRANS  input  2  transfer type; HTRANS[1]=1 means an active transfer.
- HWRITE  input  1  1 = write.
- HWDATA  input  32  write data, valid in data phase.
- HRDATA  output  32  read data, valid in data phase.
- IO_IntReq  input  N_CH  asynchronous request lines.
- IO_IntAck  output  N_CH  one-cycle pulse per channel cleared by software.
- IRQ  output  1  registered OR of (PEND & EN), to SI_Int[0].

Behaviour:
- Reset: all registers, synchronisers, HRDATA, IO_IntAck and IRQ are 0.
- Synchronisation: each IO_IntReq passes SYNC_STAGES flops, then one history flop. Edge = sync & ~history.
- Address phase: when HSEL & HTRANS[1], register the offset HADDR[4:2] and HWRITE.
- Data phase, write: HWDATA is applied to the captured offset on the next edge. The block never stalls (zero wait states) and never returns an error response.
- Data phase, read: HRDATA is registered at the edge ending the address phase, so read data is valid throughout the data phase.
- Register map (byte offsets):
  - 0x00 PEND, RO. Writing 1 to a bit clears it (write-1-to-clear, W1C).
  - 0x04 EN, RW.
  - 0x08 VEC, RO. bit31 = any enabled pending; [4:0] = lowest-index set bit of PEND&EN. Whole register reads 0 when nothing is enabled and pending.
  - 0x0C MODE, RW. Per channel: 1 = edge, 0 = level.
  - 0x10 OVF, present only with the optional feature.
  - Other offsets: reads return 0; writes are ignored.
- Register width: bits at index >= N_CH read 0 and ignore writes.
- Edge mode: PEND[i] sets on a detected edge and holds until W1C.
- Level mode: PEND[i] sets every cycle the synchronised input is 1, so a W1C has no lasting effect while the input stays high.
- Simultaneous set and W1C on the same bit in the same cycle: set wins, no event is lost, and no IO_IntAck pulse is generated for that bit.
- IO_IntAck[i]: pulses high for exactly one cycle on the edge after a W1C actually clears a 1 in PEND[i]. W1C on a bit that is already 0 gives no pulse.
- EN masks only IRQ and VEC. PEND keeps latching while a channel is disabled.
- Latency (edge mode, SYNC_STAGES=2): input high before edge 1 → PEND set at edge 3 → IRQ high at edge 4. IRQ drops one edge after PEND&EN becomes 0.
- Reset asserted mid-operation clears everything immediately. A request still high after release is treated as a new edge.

Optional Feature:
- Macro: MFP_INTC_OVF_EN.
- Defined:
  - OVF register at 0x10, W1C, sticky.
  - OVF[i] sets when an edge-mode edge arrives while PEND[i] is already 1 and not being cleared that cycle.
  - Level-mode channels never set OVF.
- Undefined: no OVF logic is built; offset 0x10 reads 0 and ignores writes.

Test Plan:
- Reset, then read offsets 0x00/0x04/0x08/0x0C → all 0x00000000; IRQ=0; IO_IntAck=0.
- EN=0xFF, MODE=0xFF, pulse IO_IntReq[5] for 1 cycle → PEND=0x20 at edge 3, IRQ=1 at edge 4, VEC=0x80000005. Write PEND=0x20 → one IO_IntAck[5] pulse, PEND=0, IRQ low one edge later.
- Edges on channels 2 and 6, EN=0x40 → VEC=0x80000006. Then EN=0x44 → VEC=0x80000002.
- MODE[3]=0, hold IO_IntReq[3] high, write PEND=0x08 → PEND still reads 0x08. Drop input, write again → PEND=0, one ack pulse.
- Edge on ch1 arriving in the same cycle as the W1C data phase for ch1 → PEND[1]=1 afterwards and no IO_IntAck[1] pulse.
- With MFP_INTC_OVF_EN, two edges on ch0 without clear → OVF=0x01. Write 0x01 to 0x10 → OVF=0. Without the macro, offset 0x10 reads 0.
